// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one external 4-bit adder, one nibble per clock, LSB nibble first.
// Latency: done is high in the cycle after edge NIBBLES counted from the accepted start; one result per NIBBLES+1 cycles.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start/opa/opb/cin   request and operands, sampled on the accepting edge
//   busy/done           busy while nibbles are added; done pulses for one cycle
//   sum/cout/ovf        result, carry-out and two's-complement overflow, valid from done
//   fa_a/fa_b/fa_cin    drive the external 4-bit adder (zero outside RUN)
//   fa_s/fa_cout        results from the external 4-bit adder
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] opa,
  input  logic [4*NIBBLES-1:0] opb,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_s,
  input  logic                 fa_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry_r;
  logic [W-1:0]    opa_r;
  logic [W-1:0]    opb_r;
  logic [IW+1:0]   bit_lo;
  logic            in_run;

  // Bit offset of the current nibble; adder inputs come from registers only,
  // so there is no combinational path from start/opa/opb or from fa_cout.
  assign bit_lo = {idx, 2'b00};
  assign in_run = (state == S_RUN);
  assign fa_a   = in_run ? opa_r[bit_lo +: 4] : 4'h0;
  assign fa_b   = in_run ? opb_r[bit_lo +: 4] : 4'h0;
  assign fa_cin = in_run ? carry_r : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      idx     <= '0;
      carry_r <= 1'b0;
      opa_r   <= '0;
      opb_r   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            opa_r   <= opa;
            opb_r   <= opb;
            carry_r <= cin;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          sum[bit_lo +: 4] <= fa_s;
          carry_r          <= fa_cout;
          if (idx == LAST) begin
            cout  <= fa_cout;
            // Overflow: operands share a sign but the top result bit differs from it.
            ovf   <= (opa_r[W-1] == opb_r[W-1]) && (fa_s[3] != opa_r[W-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// Combinational 4-bit full adder used as the nibble slice.
// Latency: zero cycles.
// Backpressure: none.
module full_adder_4bit_bh (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder with the 4-bit adder attached.
// Latency: n/a.
// Backpressure: n/a.
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          cin;
  logic          busy;
  logic          done;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic [3:0]    fa_a;
  logic [3:0]    fa_b;
  logic          fa_cin;
  logic [3:0]    fa_s;
  logic          fa_cout;

  always #5 clk = ~clk;

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
  );

  full_adder_4bit_bh fa (
    .a(fa_a), .b(fa_b), .cin(fa_cin), .s(fa_s), .cout(fa_cout)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a transaction-level view. An accepted request computes
  // its result with plain integer arithmetic, then the result appears after
  // NIB busy cycles, for one done cycle.
  bit          m_valid = 1'b0;
  int          m_cnt   = 0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic        m_cout  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [W-1:0] p_a    = '0;
  logic [W-1:0] p_sum  = '0;
  logic        p_cout  = 1'b0;
  logic        p_ovf   = 1'b0;
  int          full_u;
  int          full_s;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_cnt   = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_sum  = p_sum;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        full_u = int'(opa) + int'(opb) + int'(cin);
        full_s = int'($signed(opa)) + int'($signed(opb)) + int'(cin);
        p_a    = opa;
        p_sum  = full_u[W-1:0];
        p_cout = full_u[W];
        p_ovf  = (full_s > 32767) || (full_s < -32768);
        m_cnt  = NIB;
        m_busy = 1'b1;
      end
    end
  end

  // Compare process: every cycle after the first reset.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      if (m_busy) begin
        check("fa_a_run", 64'(fa_a), 64'((p_a >> (4 * (NIB - m_cnt))) & 16'hF));
      end else begin
        check("fa_idle", 64'({fa_a, fa_b, fa_cin}), 64'd0);
        check("sum", 64'(sum), 64'(m_sum));
        check("cout", 64'(cout), 64'(m_cout));
        check("ovf", 64'(ovf), 64'(m_ovf));
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       output int lat, output int nbusy);
    @(negedge clk);
    start = 1'b1; opa = a; opb = b; cin = c;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int lat;
  int nb;
  int k;
  int ndone;

  initial begin
    rst = 1'b1; start = 1'b0; opa = '0; opb = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_fa_a", 64'(fa_a), 64'd0);
    rst = 1'b0;

    // 1: basic add, latency and busy length
    do_op(16'h1234, 16'h4321, 1'b0, lat, nb);
    check("t1_sum", 64'(sum), 64'h5555);
    check("t1_cout", 64'(cout), 64'd0);
    check("t1_ovf", 64'(ovf), 64'd0);
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_busy_cycles", 64'(nb), 64'd4);

    // 2: carry ripples through every nibble
    do_op(16'hFFFF, 16'h0000, 1'b1, lat, nb);
    check("t2_sum", 64'(sum), 64'h0000);
    check("t2_cout", 64'(cout), 64'd1);
    check("t2_ovf", 64'(ovf), 64'd0);

    // 3: signed overflow both directions
    do_op(16'h7FFF, 16'h0001, 1'b0, lat, nb);
    check("t3a_sum", 64'(sum), 64'h8000);
    check("t3a_cout", 64'(cout), 64'd0);
    check("t3a_ovf", 64'(ovf), 64'd1);
    do_op(16'h8000, 16'h8000, 1'b0, lat, nb);
    check("t3b_sum", 64'(sum), 64'h0000);
    check("t3b_cout", 64'(cout), 64'd1);
    check("t3b_ovf", 64'(ovf), 64'd1);

    // 4: start and operand changes while busy are ignored
    @(negedge clk);
    start = 1'b1; opa = 16'h00FF; opb = 16'h0001; cin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b1;
      opa = (i == 0) ? 16'hAAAA : 16'($urandom);
      opb = (i == 0) ? 16'hAAAA : 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0; opa = 16'($urandom); opb = 16'($urandom);
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    check("t4_done_seen", 64'(done), 64'd1);
    check("t4_sum", 64'(sum), 64'h0100);
    ndone = 1;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    check("t4_done_count", 64'(ndone), 64'd1);

    // 5: reset in the middle of a run
    @(negedge clk);
    start = 1'b1; opa = 16'h1234; opb = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_sum", 64'(sum), 64'd0);
    check("t5_cout", 64'(cout), 64'd0);
    check("t5_fa_a", 64'(fa_a), 64'd0);
    rst = 1'b0;
    do_op(16'h0003, 16'h0004, 1'b0, lat, nb);
    check("t5_after_sum", 64'(sum), 64'h0007);

    // 6: back-to-back start accepted in the done cycle
    do_op(16'h0101, 16'h0202, 1'b0, lat, nb);
    check("t6_first_sum", 64'(sum), 64'h0303);
    start = 1'b1; opa = 16'h0010; opb = 16'h0020; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < 20) begin @(negedge clk); k++; end
    check("t6_gap", 64'(k), 64'd5);
    check("t6_sum", 64'(sum), 64'h0030);

    // 7: exhaustive low nibble sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          do_op(16'(a), 16'(b), c[0], lat, nb);
          check("t7_sum", 64'(sum), 64'(a + b + c));
          check("t7_cout", 64'(cout), 64'd0);
        end
      end
    end

    // Random traffic with occasional resets, checked by the model each cycle
    repeat (2000) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       opa = 16'hFFFF;
        1:       opa = 16'h7FFF;
        2:       opa = 16'h8000;
        default: opa = 16'($urandom);
      endcase
      opb = ($urandom_range(0, 4) == 0) ? 16'h0001 : 16'($urandom);
      cin = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
